// File: rtl/bcd_pkg.sv
// Shared definitions for the two-digit BCD counters (up and down).
//   bcd_t          : one 4-bit BCD digit, legal values 0..9
//   BCD_MIN/MAX    : digit range limits
//   timer_state_t  : countdown timer control states
//   is_bcd()       : true when a 4-bit value is a legal BCD digit
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MIN = 4'd0;
  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  function automatic logic is_bcd(input logic [3:0] value);
    return value <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer (purely combinational).
//   digit      : current digit value (0..9)
//   dec_en     : decrement this digit
//   digit_next : digit after the optional decrement
//   borrow     : high when a decrement of 0 wraps the digit to 9
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  bcd_t digit,
  input  logic dec_en,
  output bcd_t digit_next,
  output logic borrow
);

  always_comb begin
    digit_next = digit;
    borrow     = 1'b0;
    if (dec_en) begin
      if (digit == BCD_MIN) begin
        digit_next = BCD_MAX;
        borrow     = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (99..00) with parallel load, start/pause
// control, a prescaler between decrements and a terminal-count pulse.
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   load             : load load_tens/load_units (rejected if not BCD)
//   load_tens/units  : BCD value to load
//   start            : begin counting or resume from pause
//   pause            : hold the count while running
//   tens, units      : current count, always valid BCD
//   running          : registered, high while in RUN
//   done             : one-cycle pulse after the count reaches 00
//   load_err         : one-cycle pulse after a rejected load
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  bcd_t load_tens,
  input  bcd_t load_units,
  input  logic start,
  input  logic pause,
  output bcd_t tens,
  output bcd_t units,
  output logic running,
  output logic done,
  output logic load_err
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  timer_state_t     state_reg, state_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  bcd_t             tens_reg, tens_next;
  bcd_t             units_reg, units_next;
  logic             done_reg, done_next;
  logic             load_err_reg, load_err_next;
  logic             running_reg, running_next;

  logic enter_done;
  logic load_rejected;
  logic load_valid;
  logic pre_wrap;
  logic dec_en;
  bcd_t units_dec, tens_dec;
  logic units_borrow, tens_borrow;

  assign load_valid = is_bcd(load_tens) && is_bcd(load_units);
  assign pre_wrap   = (pre_reg == PRE_LAST);
  // A decrement is only ever requested from an uninterrupted RUN cycle.
  assign dec_en     = (state_reg == RUN) && !load && !pause && pre_wrap;

  // Units borrow ripples into the tens digit.
  bcd_digit_dec u_units_dec (
    .digit      (units_reg),
    .dec_en     (dec_en),
    .digit_next (units_dec),
    .borrow     (units_borrow)
  );

  bcd_digit_dec u_tens_dec (
    .digit      (tens_reg),
    .dec_en     (units_borrow),
    .digit_next (tens_dec),
    .borrow     (tens_borrow)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pre_reg      <= '0;
      tens_reg     <= BCD_MIN;
      units_reg    <= BCD_MIN;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      tens_reg     <= tens_next;
      units_reg    <= units_next;
      done_reg     <= done_next;
      load_err_reg <= load_err_next;
      running_reg  <= running_next;
    end
  end

  // Next-state and datapath logic; priority load > pause > start.
  always_comb begin
    state_next    = state_reg;
    pre_next      = pre_reg;
    tens_next     = tens_reg;
    units_next    = units_reg;
    enter_done    = 1'b0;
    load_rejected = 1'b0;

    if (load) begin
      if (load_valid) begin
        tens_next  = load_tens;
        units_next = load_units;
        state_next = IDLE;
        pre_next   = '0;
      end else begin
        // Rejected load freezes everything for this cycle.
        load_rejected = 1'b1;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            if (tens_reg == BCD_MIN && units_reg == BCD_MIN) begin
              state_next = DONE;
              enter_done = 1'b1;
            end else begin
              state_next = RUN;
              pre_next   = '0;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (pre_wrap) begin
            pre_next = '0;
            // tens_borrow would mean going below 00; never commit that.
            if (!tens_borrow) begin
              tens_next  = tens_dec;
              units_next = units_dec;
              if (tens_dec == BCD_MIN && units_dec == BCD_MIN) begin
                state_next = DONE;
                enter_done = 1'b1;
              end
            end
          end else begin
            pre_next = pre_reg + PRE_W'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state_next = RUN;
          end
        end
        DONE: begin
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Registered outputs; load_err is masked so it can never stay high
  // across two cycles even with an invalid load held.
  always_comb begin
    done_next     = enter_done;
    load_err_next = load_rejected && !load_err_reg;
    running_next  = (state_next == RUN);
  end

  assign tens     = tens_reg;
  assign units    = units_reg;
  assign running  = running_reg;
  assign done     = done_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, start, pause;
  logic [3:0] load_tens, load_units;

  logic [3:0] tens1, units1, tens4, units4;
  logic       running1, done1, load_err1;
  logic       running4, done4, load_err4;

  bcd_countdown_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_tens(load_tens),
    .load_units(load_units), .start(start), .pause(pause),
    .tens(tens1), .units(units1), .running(running1),
    .done(done1), .load_err(load_err1)
  );

  bcd_countdown_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_tens(load_tens),
    .load_units(load_units), .start(start), .pause(pause),
    .tens(tens4), .units(units4), .running(running4),
    .done(done4), .load_err(load_err4)
  );

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  // Reference model: count held as a plain integer 0..99.
  typedef struct {
    int value;
    int phase;
    int mode;
    bit done;
    bit err;
  } mdl_t;

  typedef struct {
    int tens;
    int units;
    bit running;
    bit done;
    bit err;
  } obs_t;

  obs_t q1[$];
  obs_t q4[$];
  mdl_t m1, m4;
  int checks   = 0;
  int failures = 0;

  function automatic mdl_t step(mdl_t m, int div, bit r, bit ld, int lt, int lu,
                                bit st, bit ps);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    n.err  = 1'b0;
    if (r) begin
      n.value = 0;
      n.phase = 0;
      n.mode  = M_IDLE;
    end else if (ld) begin
      if (lt <= 9 && lu <= 9) begin
        n.value = lt * 10 + lu;
        n.mode  = M_IDLE;
        n.phase = 0;
      end else begin
        n.err = !m.err;
      end
    end else begin
      case (m.mode)
        M_IDLE: begin
          if (st) begin
            if (m.value == 0) begin
              n.mode = M_DONE;
              n.done = 1'b1;
            end else begin
              n.mode  = M_RUN;
              n.phase = 0;
            end
          end
        end
        M_RUN: begin
          if (ps) begin
            n.mode = M_PAUSED;
          end else if (m.phase == div - 1) begin
            n.phase = 0;
            n.value = m.value - 1;
            if (n.value == 0) begin
              n.mode = M_DONE;
              n.done = 1'b1;
            end
          end else begin
            n.phase = m.phase + 1;
          end
        end
        M_PAUSED: begin
          if (st && !ps) n.mode = M_RUN;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic obs_t view(mdl_t m);
    obs_t o;
    o.tens    = m.value / 10;
    o.units   = m.value % 10;
    o.running = (m.mode == M_RUN);
    o.done    = m.done;
    o.err     = m.err;
    return o;
  endfunction

  // One stimulus cycle: drive, wait for the edge, push the model's
  // expectation for the outputs registered at that edge.
  task automatic cyc(bit r, bit ld, int lt, int lu, bit st, bit ps);
    rst        = r;
    load       = ld;
    load_tens  = lt[3:0];
    load_units = lu[3:0];
    start      = st;
    pause      = ps;
    @(posedge clk);
    m1 = step(m1, 1, r, ld, lt, lu, st, ps);
    m4 = step(m4, 4, r, ld, lt, lu, st, ps);
    q1.push_back(view(m1));
    q4.push_back(view(m4));
    if (r || ld || st || ps)
      $display("txn t=%0t rst=%0b load=%0b val=%0d/%0d start=%0b pause=%0b exp1=%0d exp4=%0d",
               $time, r, ld, lt, lu, st, ps, m1.value, m4.value);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp(string nm, logic [7:0] act, int exp);
    checks++;
    if (act !== 8'(exp)) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares the DUT outputs against the queued expectations.
  always @(negedge clk) begin
    obs_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("dut1.tens",     8'(tens1),     e.tens);
      cmp("dut1.units",    8'(units1),    e.units);
      cmp("dut1.running",  8'(running1),  int'(e.running));
      cmp("dut1.done",     8'(done1),     int'(e.done));
      cmp("dut1.load_err", 8'(load_err1), int'(e.err));
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp("dut4.tens",     8'(tens4),     e.tens);
      cmp("dut4.units",    8'(units4),    e.units);
      cmp("dut4.running",  8'(running4),  int'(e.running));
      cmp("dut4.done",     8'(done4),     int'(e.done));
      cmp("dut4.load_err", 8'(load_err4), int'(e.err));
    end
  end

  initial begin
    bit r, ld, st, ps;
    int lt, lu;
    m1 = '{value: 0, phase: 0, mode: M_IDLE, done: 1'b0, err: 1'b0};
    m4 = m1;

    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);

    // Load 12 and count to 00; digits must then hold
    cyc(0, 1, 1, 2, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(55);

    // Load 03: decrements every 4 edges on the divided instance
    cyc(0, 1, 0, 3, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(16);

    // Pause after 2 RUN cycles, hold 5 cycles, resume
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    idle(6);

    // Invalid load while holding 57, then a valid 99
    cyc(0, 1, 5, 7, 0, 0);
    cyc(0, 1, 10, 3, 0, 0);
    cyc(0, 1, 10, 3, 0, 0);
    idle(1);
    cyc(0, 1, 9, 9, 0, 0);
    idle(1);

    // Start on 00: straight to DONE, no wrap; start again ignored
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 1);
    idle(2);

    // Load 45 mid-RUN aborts the countdown
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(5);
    cyc(0, 1, 4, 5, 0, 0);
    idle(3);

    // start and pause together: RUN -> PAUSED, stays PAUSED
    cyc(0, 0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    idle(2);

    // Reset mid-RUN at 37, then start goes to DONE
    cyc(0, 1, 3, 7, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 4) == 0);
      ps = ($urandom_range(0, 9) == 0);
      lt = $urandom_range(0, 9);
      lu = $urandom_range(0, 9);
      if (ld && m1.mode != M_RUN && m4.mode != M_RUN &&
          $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) lt = $urandom_range(10, 15);
        else lu = $urandom_range(10, 15);
      end
      cyc(r, ld, lt, lu, st, ps);
    end
    idle(2);

    // Every queued expectation must have been consumed by the monitor
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d/%0d required=0/0", q1.size(), q4.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
